// File: rtl/seqmul_pkg.sv
// Shared definitions for the sequential-multiplier accumulator slice:
// default widths, the accumulator FSM state type and a width helper.
package seqmul_pkg;

    localparam int PW_DEFAULT      = 8;
    localparam int N_TERMS_DEFAULT = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Counters need at least one bit even for a single-term frame.
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/seqmul_acc_if.sv
// Product-in / frame-sum-out stream pair for seqmul_acc.
// slave is the accumulator side, master is the producer/consumer side.
interface seqmul_acc_if
    import seqmul_pkg::*;
#(
    parameter int PW = PW_DEFAULT,
    parameter int AW = 10
);
    // Both streams use plain valid/ready: a transfer happens on a rising
    // edge where valid && ready; valid never waits on ready, and the
    // payload is held stable by its source while valid && !ready.
    logic          in_valid;
    logic [PW-1:0] in_prod;
    logic          in_ready;

    logic          out_valid;
    logic [AW-1:0] out_sum;
    logic          out_ovf;
    logic          out_ready;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/seqmul_acc.sv
// Accumulates N_TERMS multiplier products into one frame sum with sticky
// overflow. Define SEQMUL_ACC_SAT_EN to clamp the sum instead of wrapping.
module seqmul_acc
    import seqmul_pkg::*;
#(
    parameter int PW      = PW_DEFAULT,
    parameter int N_TERMS = N_TERMS_DEFAULT,
    parameter int AW      = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    seqmul_acc_if.slave  bus,
    output logic         busy,
    output state_t       dbg_state
);

    localparam int             CW   = cnt_width(N_TERMS);
    localparam logic [CW-1:0]  LAST = CW'(N_TERMS - 1);

    state_t        state;
    logic [AW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          out_valid_q;

    logic          accept;
    logic [AW:0]   sum_ext;
    logic          carry;
    logic [AW-1:0] sum_nxt;

    assign bus.in_ready  = (state == ACCUM) && !clear;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum;
    assign bus.out_ovf   = ovf;
    assign busy          = (cnt != '0) || (state == HOLD);
    assign dbg_state     = state;

    // One extra bit on the adder exposes the carry that drives the sticky flag.
    always_comb begin
        sum_ext = {1'b0, sum} + (AW + 1)'(bus.in_prod);
        carry   = sum_ext[AW];
`ifdef SEQMUL_ACC_SAT_EN
        sum_nxt = carry ? '1 : sum_ext[AW-1:0];
`else
        sum_nxt = sum_ext[AW-1:0];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ACCUM;
            sum         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            state       <= ACCUM;
            sum         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        sum <= sum_nxt;
                        ovf <= ovf | carry;
                        if (cnt == LAST) begin
                            // Counter restarts here so it never wraps; HOLD keeps busy high.
                            cnt         <= '0;
                            state       <= HOLD;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= ACCUM;
                        sum         <= '0;
                        cnt         <= '0;
                        ovf         <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ACCUM;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
